fetch_unit: RTL and testbench

Instruction-fetch stage of the simplified MIPS core. It holds the program counter, drives Read_address of the combinational instr_memory, and registers the returned Instruction into the IF/ID pipeline register. It also handles stall, flush/redirect (branch, jump) and a halt state entered on a sentinel instruction word.

---
 rtl/mips_pkg.sv | 13 +
 rtl/pc_reg.sv | 33 +++
 rtl/fetch_unit.sv | 75 +++++++
 tb/tb_fetch_unit.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the simplified MIPS core's front end.
package mips_pkg;

  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam int          PC_STEP          = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register with its next-PC mux: reset, redirect load, hold, or step.
module pc_reg
  import mips_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  hold,
  input  logic [ADDR_WIDTH-1:0] target,
  output logic [ADDR_WIDTH-1:0] pc
);

  logic [ADDR_WIDTH-1:0] target_aligned;

  // Redirect targets are word addresses; the two low bits are dropped.
  assign target_aligned = target & ~ADDR_WIDTH'(3);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= target_aligned;
    end else if (!hold) begin
      pc <= pc + ADDR_WIDTH'(PC_STEP);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, IF/ID pipeline register, and run/halt control.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Stall,
  input  logic                  Redirect,
  input  logic [ADDR_WIDTH-1:0] Redirect_target,
  output logic [ADDR_WIDTH-1:0] Read_address,
  input  logic [DATA_WIDTH-1:0] Instruction,
  output logic [DATA_WIDTH-1:0] IFID_instruction,
  output logic [ADDR_WIDTH-1:0] IFID_pc_plus4,
  output logic                  IFID_valid,
  output logic                  Halted
);

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic                  is_halt_word;
  logic                  pc_hold;

  assign Read_address = pc;
  assign pc_plus4     = pc + ADDR_WIDTH'(PC_STEP);
  assign is_halt_word = (Instruction == HALT_WORD);

  // The PC freezes while halted, while stalled, and on the edge that sees the halt word.
  assign pc_hold = (state == S_HALT) || Stall || is_halt_word;

  pc_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (Redirect),
    .hold   (pc_hold),
    .target (Redirect_target),
    .pc     (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_RUN;
      IFID_instruction <= DATA_WIDTH'(NOP_WORD);
      IFID_pc_plus4    <= '0;
      IFID_valid       <= 1'b0;
      Halted           <= 1'b0;
    end else if (Redirect) begin
      // Flush wins over stall and also releases a halt; pc_plus4 keeps its old value.
      state            <= S_RUN;
      IFID_instruction <= DATA_WIDTH'(NOP_WORD);
      IFID_valid       <= 1'b0;
      Halted           <= 1'b0;
    end else if (state == S_RUN && !Stall) begin
      if (is_halt_word) begin
        state            <= S_HALT;
        IFID_instruction <= DATA_WIDTH'(NOP_WORD);
        IFID_valid       <= 1'b0;
        Halted           <= 1'b1;
      end else begin
        IFID_instruction <= Instruction;
        IFID_pc_plus4    <= pc_plus4;
        IFID_valid       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a driver queues hand-computed post-edge state, a monitor checks it.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        Stall;
  logic        Redirect;
  logic [31:0] Redirect_target;
  logic [31:0] Read_address;
  logic [31:0] Instruction;
  logic [31:0] IFID_instruction;
  logic [31:0] IFID_pc_plus4;
  logic        IFID_valid;
  logic        Halted;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .Stall            (Stall),
    .Redirect         (Redirect),
    .Redirect_target  (Redirect_target),
    .Read_address     (Read_address),
    .Instruction      (Instruction),
    .IFID_instruction (IFID_instruction),
    .IFID_pc_plus4    (IFID_pc_plus4),
    .IFID_valid       (IFID_valid),
    .Halted           (Halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_read(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: return 32'h2008_0001;
      32'h0000_0004: return 32'h2009_0002;
      32'h0000_0008: return 32'h200A_0003;
      32'h0000_000C: return 32'h200B_0004;
      32'h0000_0010: return 32'h200C_0005;
      32'h0000_0014: return 32'hFFFF_FFFF;
      32'h0000_0020: return 32'h2400_0008;
      32'h0000_0040: return 32'h2010_0010;
      32'hFFFF_FFFC: return 32'h2400_0007;
      default:       return 32'h0000_0000;
    endcase
  endfunction

  always_comb Instruction = mem_read(Read_address);

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drive one cycle's inputs and queue the state expected right after the next edge.
  task automatic cyc(input string name, input logic r, input logic st, input logic rd,
                     input logic [31:0] tgt, input logic [31:0] e_pc, input logic [31:0] e_instr,
                     input logic [31:0] e_pc4, input logic e_valid, input logic e_halted);
    exp_t e;
    @(negedge clk);
    rst             = r;
    Stall           = st;
    Redirect        = rd;
    Redirect_target = tgt;
    e.name   = name;
    e.pc     = e_pc;
    e.instr  = e_instr;
    e.pc4    = e_pc4;
    e.valid  = e_valid;
    e.halted = e_halted;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".pc"},     Read_address,            e.pc);
        check({e.name, ".instr"},  IFID_instruction,        e.instr);
        check({e.name, ".pc4"},    IFID_pc_plus4,           e.pc4);
        check({e.name, ".valid"},  {31'b0, IFID_valid},     {31'b0, e.valid});
        check({e.name, ".halted"}, {31'b0, Halted},         {31'b0, e.halted});
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    rst = 1'b1; Stall = 1'b0; Redirect = 1'b0; Redirect_target = '0;
    //  name          rst  stl  rdr  target          pc             instr          pc4            v  h
    cyc("reset0",     1,   0,   0,   32'h0,          32'h0,         32'h0,         32'h0,         0, 0);
    cyc("reset1",     1,   0,   0,   32'h0,          32'h0,         32'h0,         32'h0,         0, 0);
    cyc("run0",       0,   0,   0,   32'h0,          32'h4,         32'h2008_0001, 32'h4,         1, 0);
    cyc("run1",       0,   0,   0,   32'h0,          32'h8,         32'h2009_0002, 32'h8,         1, 0);
    cyc("stall0",     0,   1,   0,   32'h0,          32'h8,         32'h2009_0002, 32'h8,         1, 0);
    cyc("stall1",     0,   1,   0,   32'h0,          32'h8,         32'h2009_0002, 32'h8,         1, 0);
    cyc("stall2",     0,   1,   0,   32'h0,          32'h8,         32'h2009_0002, 32'h8,         1, 0);
    cyc("resume",     0,   0,   0,   32'h0,          32'hC,         32'h200A_0003, 32'hC,         1, 0);
    cyc("run2",       0,   0,   0,   32'h0,          32'h10,        32'h200B_0004, 32'h10,        1, 0);
    cyc("redir_stl",  0,   1,   1,   32'h40,         32'h40,        32'h0,         32'h10,        0, 0);
    cyc("fetch40",    0,   0,   0,   32'h0,          32'h44,        32'h2010_0010, 32'h44,        1, 0);
    cyc("redir43",    0,   0,   1,   32'h43,         32'h40,        32'h0,         32'h44,        0, 0);
    cyc("redir10",    0,   0,   1,   32'h10,         32'h10,        32'h0,         32'h44,        0, 0);
    cyc("fetch10",    0,   0,   0,   32'h0,          32'h14,        32'h200C_0005, 32'h14,        1, 0);
    cyc("halt_stl",   0,   1,   0,   32'h0,          32'h14,        32'h200C_0005, 32'h14,        1, 0);
    cyc("halt",       0,   0,   0,   32'h0,          32'h14,        32'h0,         32'h14,        0, 1);
    cyc("halted0",    0,   0,   0,   32'h0,          32'h14,        32'h0,         32'h14,        0, 1);
    cyc("halted1",    0,   0,   0,   32'h0,          32'h14,        32'h0,         32'h14,        0, 1);
    cyc("halted_stl", 0,   1,   0,   32'h0,          32'h14,        32'h0,         32'h14,        0, 1);
    cyc("unhalt",     0,   0,   1,   32'h0,          32'h0,         32'h0,         32'h14,        0, 0);
    cyc("restart",    0,   0,   0,   32'h0,          32'h4,         32'h2008_0001, 32'h4,         1, 0);
    cyc("redir_top",  0,   0,   1,   32'hFFFF_FFFC,  32'hFFFF_FFFC, 32'h0,         32'h4,         0, 0);
    cyc("wrap",       0,   0,   0,   32'h0,          32'h0,         32'h2400_0007, 32'h0,         1, 0);
    cyc("redir20",    0,   0,   1,   32'h20,         32'h20,        32'h0,         32'h0,         0, 0);
    cyc("fetch20",    0,   0,   0,   32'h0,          32'h24,        32'h2400_0008, 32'h24,        1, 0);
    cyc("mid_rst",    1,   0,   0,   32'h0,          32'h0,         32'h0,         32'h0,         0, 0);
    cyc("post_rst",   0,   0,   0,   32'h0,          32'h4,         32'h2008_0001, 32'h4,         1, 0);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
